// File: rtl/alu_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_stage
// Description : Single-issue integer ALU stage with registered outputs.
//               Arithmetic, logic and compare operations complete on the first
//               clock edge after they are presented. Shifts either complete in
//               one cycle (barrel shifter) or run one bit per cycle, stalling
//               upstream via out_stall until the final edge.
// Config      : FAST_SHIFT_EN - defined: barrel shifter, out_stall tied low.
//                               undefined: iterative 1-bit/cycle shifter.
// Ports       : clk        in   clock, all state on rising edge
//               rst_n      in   asynchronous active-low reset
//               in_noop    in   upstream bubble flag
//               in_op      in   [3:0] operation code (encoding below)
//               in_src1    in   [31:0] first operand
//               in_src2    in   [31:0] second operand / shift amount
//               out_stall  out  combinational hold request to upstream
//               out_noop   out  registered bubble flag
//               out_result out  [31:0] registered result
//               out_cond   out  registered comparison outcome
// Revision    : 1.0 - initial release
// ============================================================================
module alu_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_noop,
    input  logic [3:0]  in_op,
    input  logic [31:0] in_src1,
    input  logic [31:0] in_src2,
    output logic        out_stall,
    output logic        out_noop,
    output logic [31:0] out_result,
    output logic        out_cond
);

    // Operation encoding
    localparam logic [3:0] C_OP_NO_OP = 4'd0;
    localparam logic [3:0] C_OP_ADD   = 4'd1;
    localparam logic [3:0] C_OP_SUB   = 4'd2;
    localparam logic [3:0] C_OP_XOR   = 4'd3;
    localparam logic [3:0] C_OP_OR    = 4'd4;
    localparam logic [3:0] C_OP_AND   = 4'd5;
    localparam logic [3:0] C_OP_SLL   = 4'd6;
    localparam logic [3:0] C_OP_SRL   = 4'd7;
    localparam logic [3:0] C_OP_SRA   = 4'd8;
    localparam logic [3:0] C_OP_LT    = 4'd9;
    localparam logic [3:0] C_OP_LTU   = 4'd10;
    localparam logic [3:0] C_OP_EQ    = 4'd11;
    localparam logic [3:0] C_OP_NEQ   = 4'd12;
    localparam logic [3:0] C_OP_GE    = 4'd13;
    localparam logic [3:0] C_OP_GEU   = 4'd14;

    logic        w_valid;
    logic        w_is_shift;
    logic [4:0]  w_shamt;
    logic [31:0] w_result;
    logic        w_cond;

    assign w_valid    = !in_noop && (in_op != C_OP_NO_OP);
    assign w_is_shift = (in_op == C_OP_SLL) || (in_op == C_OP_SRL) || (in_op == C_OP_SRA);
    assign w_shamt    = in_src2[4:0];

    // Single-cycle result. In the iterative build the shift arms are only
    // reached with a zero shift amount, so they simply pass in_src1 through.
    always_comb begin
        w_result = 32'd0;
        w_cond   = 1'b0;
        case (in_op)
            C_OP_ADD: w_result = in_src1 + in_src2;
            C_OP_SUB: w_result = in_src1 - in_src2;
            C_OP_XOR: w_result = in_src1 ^ in_src2;
            C_OP_OR:  w_result = in_src1 | in_src2;
            C_OP_AND: w_result = in_src1 & in_src2;
`ifdef FAST_SHIFT_EN
            C_OP_SLL: w_result = in_src1 << w_shamt;
            C_OP_SRL: w_result = in_src1 >> w_shamt;
            C_OP_SRA: w_result = $signed(in_src1) >>> w_shamt;
`else
            C_OP_SLL,
            C_OP_SRL,
            C_OP_SRA: w_result = in_src1;
`endif
            C_OP_LT:  w_cond = $signed(in_src1) <  $signed(in_src2);
            C_OP_LTU: w_cond = in_src1 <  in_src2;
            C_OP_EQ:  w_cond = in_src1 == in_src2;
            C_OP_NEQ: w_cond = in_src1 != in_src2;
            C_OP_GE:  w_cond = $signed(in_src1) >= $signed(in_src2);
            C_OP_GEU: w_cond = in_src1 >= in_src2;
            default:  w_result = 32'd0;
        endcase
        if (in_op >= C_OP_LT) begin
            w_result = {31'd0, w_cond};
        end
    end

`ifdef FAST_SHIFT_EN

    assign out_stall = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_noop   <= 1'b1;
            out_result <= 32'd0;
            out_cond   <= 1'b0;
        end else if (w_valid) begin
            out_noop   <= 1'b0;
            out_result <= w_result;
            out_cond   <= w_cond;
        end else begin
            out_noop   <= 1'b1;
            out_result <= 32'd0;
            out_cond   <= 1'b0;
        end
    end

`else

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    localparam logic [1:0] C_KIND_SLL = 2'd0;
    localparam logic [1:0] C_KIND_SRL = 2'd1;
    localparam logic [1:0] C_KIND_SRA = 2'd2;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_acc;
    logic [4:0]  r_cnt;
    logic [1:0]  r_kind;
    logic        w_shift_start;
    logic        w_last;
    logic [31:0] w_acc_shifted;
    logic [1:0]  w_kind_in;

    assign w_shift_start = w_valid && w_is_shift && (w_shamt != 5'd0);
    assign w_last        = (r_cnt == 5'd1);

    // Reset forces the stall low even if a shift is being presented.
    assign out_stall = rst_n && (((r_state == S_IDLE) && w_shift_start) ||
                                 ((r_state == S_SHIFT) && !w_last));

    always_comb begin
        w_kind_in = C_KIND_SLL;
        if (in_op == C_OP_SRL) w_kind_in = C_KIND_SRL;
        if (in_op == C_OP_SRA) w_kind_in = C_KIND_SRA;
    end

    always_comb begin
        w_acc_shifted = {r_acc[30:0], 1'b0};
        case (r_kind)
            C_KIND_SRL: w_acc_shifted = {1'b0, r_acc[31:1]};
            C_KIND_SRA: w_acc_shifted = {r_acc[31], r_acc[31:1]};
            default:    w_acc_shifted = {r_acc[30:0], 1'b0};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_shift_start) w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_last)        w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath and output registers. Inputs are only sampled in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc      <= 32'd0;
            r_cnt      <= 5'd0;
            r_kind     <= C_KIND_SLL;
            out_noop   <= 1'b1;
            out_result <= 32'd0;
            out_cond   <= 1'b0;
        end else if (r_state == S_SHIFT) begin
            r_acc    <= w_acc_shifted;
            r_cnt    <= r_cnt - 5'd1;
            out_cond <= 1'b0;
            if (w_last) begin
                out_noop   <= 1'b0;
                out_result <= w_acc_shifted;
            end else begin
                out_noop   <= 1'b1;
                out_result <= 32'd0;
            end
        end else if (w_shift_start) begin
            r_acc      <= in_src1;
            r_cnt      <= w_shamt;
            r_kind     <= w_kind_in;
            out_noop   <= 1'b1;
            out_result <= 32'd0;
            out_cond   <= 1'b0;
        end else if (w_valid) begin
            out_noop   <= 1'b0;
            out_result <= w_result;
            out_cond   <= w_cond;
        end else begin
            out_noop   <= 1'b1;
            out_result <= 32'd0;
            out_cond   <= 1'b0;
        end
    end

`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_stage
// Description : Scoreboard bench for alu_stage. Stimulus pushes the expected
//               {cond, result} of each valid op; a monitor pops and compares
//               whenever out_noop is low. Honours FAST_SHIFT_EN for the
//               expected stall count.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_stage;

    localparam logic [3:0] NO_OP = 4'd0,  ADD = 4'd1,  SUB = 4'd2,  XOR_ = 4'd3,
                           OR_   = 4'd4,  AND_ = 4'd5, SLL = 4'd6,  SRL = 4'd7,
                           SRA   = 4'd8,  LT = 4'd9,   LTU = 4'd10, EQ = 4'd11,
                           NEQ   = 4'd12, GE = 4'd13,  GEU = 4'd14;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_noop;
    logic [3:0]  in_op;
    logic [31:0] in_src1;
    logic [31:0] in_src2;
    logic        out_stall;
    logic        out_noop;
    logic [31:0] out_result;
    logic        out_cond;

    int total = 0;
    int bad   = 0;
    logic [32:0] sb[$];

    alu_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_noop   (in_noop),
        .in_op     (in_op),
        .in_src1   (in_src1),
        .in_src2   (in_src2),
        .out_stall (out_stall),
        .out_noop  (out_noop),
        .out_result(out_result),
        .out_cond  (out_cond)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: returns {cond, result} straight from the operation rules.
    function automatic logic [32:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        int unsigned sh;
        logic [31:0] r;
        logic        c;
        sh = b % 32;
        r  = 32'd0;
        c  = 1'b0;
        case (op)
            ADD:  r = a + b;
            SUB:  r = a - b;
            XOR_: r = a ^ b;
            OR_:  r = a | b;
            AND_: r = a & b;
            SLL:  r = a << sh;
            SRL:  r = a >> sh;
            SRA:  r = $signed(a) >>> sh;
            LT:   c = $signed(a) <  $signed(b);
            LTU:  c = a <  b;
            EQ:   c = a == b;
            NEQ:  c = a != b;
            GE:   c = $signed(a) >= $signed(b);
            GEU:  c = a >= b;
            default: r = 32'd0;
        endcase
        if (op >= LT) r = c ? 32'd1 : 32'd0;
        return {c, r};
    endfunction

    // Present one instruction, hold it while out_stall is high, then let the
    // next rising edge consume it.
    task automatic issue(input logic noop, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        bit valid;
        int stalls;
        int exp_stalls;
        bit done;
        @(negedge clk);
        in_noop = noop;
        in_op   = op;
        in_src1 = a;
        in_src2 = b;
        valid   = !noop && (op != NO_OP);
        if (valid) sb.push_back(model(op, a, b));
        exp_stalls = 0;
`ifndef FAST_SHIFT_EN
        if (valid && (op == SLL || op == SRL || op == SRA)) exp_stalls = int'(b % 32);
`endif
        stalls = 0;
        done   = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (!out_stall) begin
                done = 1;
                break;
            end
            stalls++;
            @(negedge clk);
        end
        chk("stall_bound", 32'(done), 32'd1);
        chk("stall_cycles", stalls, exp_stalls);
        @(posedge clk);
        #1;
        if (valid) begin
            chk("noop_after_op", 32'(out_noop), 32'd0);
        end else begin
            chk("bubble_noop", 32'(out_noop), 32'd1);
            chk("bubble_result", out_result, 32'd0);
            chk("bubble_cond", 32'(out_cond), 32'd0);
        end
    endtask

    // Monitor: every completed op is checked against the scoreboard head.
    always @(posedge clk) begin
        logic [32:0] e;
        #1;
        if (rst_n && !out_noop) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result actual=%h required=none", out_result);
            end else begin
                e = sb.pop_front();
                chk("sb_result", out_result, e[31:0]);
                chk("sb_cond", 32'(out_cond), 32'(e[32]));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0]  op;
        logic [31:0] a, b;
        logic        nop;

        // Reset with a valid shift presented: stall must stay low.
        rst_n   = 1'b0;
        in_noop = 1'b0;
        in_op   = SLL;
        in_src1 = 32'h1;
        in_src2 = 32'd5;
        #12;
        chk("reset_stall", 32'(out_stall), 32'd0);
        chk("reset_noop", 32'(out_noop), 32'd1);
        chk("reset_result", out_result, 32'd0);
        chk("reset_cond", 32'(out_cond), 32'd0);
        @(negedge clk);
        in_noop = 1'b1;
        rst_n   = 1'b1;

        // Directed cases
        issue(0, ADD, 32'h7FFFFFFF, 32'h1);
        issue(0, SRA, 32'h80000000, 32'h24);
        issue(0, LT,  32'hFFFFFFFF, 32'h1);
        issue(0, LTU, 32'hFFFFFFFF, 32'h1);
        issue(0, SLL, 32'h1234,     32'h0);
        issue(1, ADD, 32'h5,        32'h6);
        issue(0, NO_OP, 32'h5,      32'h6);
        issue(0, SRL, 32'h80000000, 32'hFFFFFFFF);
        issue(0, SUB, 32'h0,        32'h1);
        issue(0, GE,  32'h80000000, 32'h7FFFFFFF);
        issue(0, GEU, 32'h80000000, 32'h7FFFFFFF);
        issue(0, EQ,  32'hDEADBEEF, 32'hDEADBEEF);

        // Random traffic
        for (int i = 0; i < 200; i++) begin
            op  = 4'($urandom_range(0, 14));
            nop = ($urandom_range(0, 9) == 0);
            a   = $urandom;
            b   = $urandom;
            if ($urandom_range(0, 3) == 0) b[4:0] = 5'd0;
            if ($urandom_range(0, 5) == 0) b = a;
            issue(nop, op, a, b);
        end

        // Reset in the middle of a 10-bit shift.
        @(negedge clk);
        in_noop = 1'b0;
        in_op   = SLL;
        in_src1 = 32'h1;
        in_src2 = 32'd10;
`ifdef FAST_SHIFT_EN
        sb.push_back(model(SLL, 32'h1, 32'd10));
`endif
        @(posedge clk);
        @(negedge clk);
        in_noop = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_stall", 32'(out_stall), 32'd0);
        chk("midreset_noop", 32'(out_noop), 32'd1);
        chk("midreset_result", out_result, 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        in_noop = 1'b0;
        in_op   = ADD;
        in_src1 = 32'd2;
        in_src2 = 32'd3;
        sb.push_back(model(ADD, 32'd2, 32'd3));
        @(posedge clk);
        #1;
        chk("post_reset_noop", 32'(out_noop), 32'd0);
        chk("post_reset_result", out_result, 32'd5);
        @(negedge clk);
        in_noop = 1'b1;

        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_stage.md
ALU_STAGE -- requirements
Module: alu_stage

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: in_noop  in  1  upstream bubble flag.
REQ-004 SHALL have ports: in_op  in  op_t  operation (NO_OP, ADD, SUB, XOR, OR, AND, SLL, SRL, SRA, LT, LTU, EQ, NEQ, GE, GEU).
REQ-005 SHALL have ports: in_src1 / in_src2  in  32 each  signed operands.
REQ-006 SHALL have ports: out_stall  out  1  combinational; upstream holds its outputs while high.
REQ-007 SHALL have ports: out_noop  out  1  registered bubble flag.
REQ-008 SHALL have ports: out_result  out  32  registered result.
REQ-009 SHALL have ports: out_cond  out  1  registered comparison outcome.

Function
REQ-010 Valid op: in_noop=0 and in_op!=NO_OP; otherwise next edge: out_noop=1, out_result=0, out_cond=0.
REQ-011 Single-cycle ops: result registered on the first edge after presentation, out_noop=0.
REQ-012 ADD/SUB: modulo 2^32, no overflow flag; XOR/OR/AND bitwise.
REQ-013 Shift amount SHALL be in_src2[4:0]; bits [31:5] ignored. SRA sign-fills; SRL/SLL zero-fill.
REQ-014 LT/GE signed, LTU/GEU unsigned, EQ/NEQ bitwise. out_cond = comparison true. out_result = 32'h1 if true, else 0.
REQ-015 Non-comparison ops SHALL drive out_cond=0.
REQ-016 FSM states: IDLE, SHIFT. Only used when the iterative shifter is compiled in (REQ-024).
REQ-017 IDLE -> SHIFT: at an edge in IDLE with a valid SLL/SRL/SRA and shamt n>0.
    - Load acc=in_src1, cnt=n, latch the shift kind.
    - Register out_noop=1.
REQ-018 Each edge in SHIFT: acc shifted one bit per the latched kind, cnt decremented.
REQ-019 At the SHIFT edge with cnt==1: register out_result = final acc, out_noop=0, out_cond=0; go to IDLE.
    - All other SHIFT edges register out_noop=1.
REQ-020 Shift with n=0 SHALL complete single-cycle (out_result=in_src1), no SHIFT entry.
REQ-021 out_stall = (IDLE and shift start per REQ-017) or (SHIFT and cnt!=1).
    - Gives exactly n stall cycles and result at edge E0+n, where E0 is the accept edge.
REQ-022 Inputs presented while in SHIFT SHALL be ignored. The next instruction is sampled only in IDLE.

Reset
REQ-023 rst_n low, asynchronously: state=IDLE, cnt=0, acc=0, out_noop=1, out_result=0, out_cond=0, out_stall=0.
    - Applies mid-shift; the in-flight shift is discarded.
    - First valid op is accepted on the first edge after rst_n rises.

Configuration
REQ-024 Macro FAST_SHIFT_EN selects the shifter.
    - Defined: shifts are single-cycle barrel shifts; no SHIFT state; out_stall tied 0.
    - Undefined: iterative 1-bit/cycle shifter per REQ-016..REQ-022.
    - All non-shift behaviour SHALL be identical in both builds.

Verification
REQ-025 ADD src1=0x7FFFFFFF, src2=1 -> next edge out_result=0x80000000, out_noop=0, out_stall never high.
REQ-026 SRA src1=0x80000000, src2=0x24 (shamt 4), FAST_SHIFT_EN undefined.
    - out_stall high 4 cycles; out_noop=1 on edges E0..E0+3.
    - Edge E0+4: out_result=0xF8000000, out_noop=0.
    - With FAST_SHIFT_EN defined: same result at E0+1, out_stall=0.
REQ-027 LT src1=0xFFFFFFFF, src2=1 -> out_result=1, out_cond=1.
    - LTU on the same operands -> out_result=0, out_cond=0.
REQ-028 SLL src1=0x1234, src2=0 -> next edge out_result=0x1234, no stall.
    - in_noop=1 with op ADD -> out_noop=1, out_result=0.
REQ-029 SLL shamt 10: assert rst_n low after 3 SHIFT cycles.
    - Immediately: out_stall=0, out_noop=1, out_result=0.
    - Then ADD 2+3 after release -> out_result=5 on first edge.
